circle_position_ctrl: RTL
=========================

CIRCLE_POSITION_CTRL -- requirements
Module: circle_position_ctrl

Interface
REQ-001 SHALL have parameter DISPLAY_COUNT, default 6, number of 7-segment displays in the chain.
REQ-002 SHALL have parameter COL_WIDTH, default $clog2(DISPLAY_COUNT), width of the column index.
REQ-003 SHALL have parameter BASE_DIV, default 12_500_000, clock cycles per step at speed 0.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 start  input  1  single-cycle pulse; begin or resume animation.
REQ-008 stop  input  1  single-cycle pulse; pause animation.
REQ-009 dir  input  1  path direction: 0 clockwise, 1 counter-clockwise.
REQ-010 speed  input  2  step period select; period = BASE_DIV*(speed+1) cycles.
REQ-011 row  output  1  circle row to display driver: 0 top segment, 1 bottom segment.
REQ-012 col  output  COL_WIDTH  circle column index to display driver, 0..DISPLAY_COUNT-1.
REQ-013 step  output  1  one-cycle pulse in the cycle row/col take a new value.
REQ-014 running  output  1  high while in RUN state.

Function
REQ-015 Path SHALL be a closed loop of 2*DISPLAY_COUNT positions; row/col SHALL always be on it.
REQ-016 dir=0 step: row0 col<N-1 -> col+1; row0 col N-1 -> row1 same col; row1 col>0 -> col-1; row1 col0 -> row0 col0.
REQ-017 dir=1 step SHALL be the exact inverse of REQ-016 (e.g. row0 col0 -> row1 col0).
REQ-018 FSM SHALL have two states: IDLE (position held, prescaler at 0) and RUN.
REQ-019 IDLE -> RUN on start; RUN -> IDLE on stop; start while RUN SHALL be ignored.
REQ-020 start and stop in same cycle SHALL be treated as stop (IDLE result in either state).
REQ-021 In RUN the prescaler SHALL increment each cycle; when count >= BASE_DIV*(speed+1)-1 it SHALL clear, position SHALL advance, step SHALL pulse, all in one edge.
REQ-022 First step after IDLE->RUN SHALL occur exactly BASE_DIV*(speed+1) cycles after the cycle start is sampled.
REQ-023 speed change mid-run SHALL apply immediately; if count already exceeds new limit, step SHALL fire on next edge.
REQ-024 dir SHALL be sampled at the stepping edge; change between steps SHALL not move position.
REQ-025 stop coincident with a tick SHALL win: no advance, no step, prescaler cleared.
REQ-026 Stopping SHALL retain row/col; resuming SHALL continue from retained position.
REQ-027 Prescaler SHALL be wide enough for 4*BASE_DIV-1 with no overflow.
REQ-028 row/col/step/running SHALL be registered outputs (no combinational path from inputs).

Reset
REQ-029 On rst assertion, asynchronously: state IDLE, prescaler 0, row 0, col 0, step 0, running 0.
REQ-030 rst asserted mid-run SHALL abandon any pending step; no step pulse after release until a new start.

Structure
REQ-031 Package circle7seg_pkg SHALL hold the state enum (IDLE, RUN) and the DISPLAY_COUNT default constant, shared with the display driver.
REQ-032 Prescaler SHALL be a sub-module tick_prescaler (inputs clk, rst, clear, enable, limit; output tick).
REQ-033 row/col SHALL connect directly to the display driver's row/col inputs with matching widths.

Verification (bench uses DISPLAY_COUNT=6, BASE_DIV=4)
REQ-034 Reset, start, dir=0, speed=0 -> step every 4 cycles; positions (0,0)(0,1)..(0,5)(1,5)(1,4)..(1,0)(0,0) over 12 steps.
REQ-035 From (0,0), dir=1, run one step -> (1,0); next -> (1,1).
REQ-036 speed=3 -> step period 16 cycles; switch to speed=0 when count=10 -> step on next edge, then every 4 cycles.
REQ-037 stop in the tick cycle -> no step, position unchanged, running=0; start 5 cycles later -> next step exactly 4 cycles after start.
REQ-038 start and stop same cycle from IDLE -> stays IDLE, running=0, no step for 20 cycles.
REQ-039 rst pulse mid-run at count 2 -> outputs immediately (0,0), step 0, running 0; no step after release without start.

Source files
------------

// File: rtl/circle7seg_pkg.sv
// rtl/circle7seg_pkg.sv - shared state encoding and display chain defaults
package circle7seg_pkg;

    localparam int DISPLAY_COUNT_DEFAULT = 6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running cycle counter that flags when it reaches a limit
module tick_prescaler #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             tick
);

    logic [WIDTH-1:0] count;

    // ">=" rather than "==" so a lowered limit fires on the very next edge
    assign tick = enable && (count >= limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (tick) begin
                count <= '0;
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/circle_position_ctrl.sv
// rtl/circle_position_ctrl.sv - walks a dot around the top/bottom segment loop of a 7-seg chain
module circle_position_ctrl
    import circle7seg_pkg::*;
#(
    parameter int DISPLAY_COUNT = DISPLAY_COUNT_DEFAULT,
    parameter int COL_WIDTH     = $clog2(DISPLAY_COUNT),
    parameter int BASE_DIV      = 12_500_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 dir,
    input  logic [1:0]           speed,
    output logic                 row,
    output logic [COL_WIDTH-1:0] col,
    output logic                 step,
    output logic                 running
);

    localparam int                   PRESC_WIDTH = $clog2(4 * BASE_DIV);
    localparam logic [COL_WIDTH-1:0] LAST_COL    = COL_WIDTH'(DISPLAY_COUNT - 1);

    state_t                 state;
    state_t                 next_state;
    logic                   tick;
    logic                   advance;
    logic                   presc_clear;
    logic                   presc_enable;
    logic [PRESC_WIDTH-1:0] limit;
    logic                   next_row;
    logic [COL_WIDTH-1:0]   next_col;

    assign limit = PRESC_WIDTH'(BASE_DIV * (int'(speed) + 1) - 1);

    tick_prescaler #(
        .WIDTH (PRESC_WIDTH)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clear  (presc_clear),
        .enable (presc_enable),
        .limit  (limit),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // stop dominates start in both states
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && !stop) next_state = RUN;
            RUN:     if (stop)           next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        presc_enable = (state == RUN);
        presc_clear  = (state == IDLE) || (next_state == IDLE);
        advance      = (state == RUN) && tick && !stop;

        next_row = row;
        next_col = col;
        if (!dir) begin
            if (!row) begin
                if (col == LAST_COL) next_row = 1'b1;
                else                 next_col = col + COL_WIDTH'(1);
            end else begin
                if (col == '0)       next_row = 1'b0;
                else                 next_col = col - COL_WIDTH'(1);
            end
        end else begin
            if (!row) begin
                if (col == '0)       next_row = 1'b1;
                else                 next_col = col - COL_WIDTH'(1);
            end else begin
                if (col == LAST_COL) next_row = 1'b0;
                else                 next_col = col + COL_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row     <= 1'b0;
            col     <= '0;
            step    <= 1'b0;
            running <= 1'b0;
        end else begin
            step    <= advance;
            running <= (next_state == RUN);
            if (advance) begin
                row <= next_row;
                col <= next_col;
            end
        end
    end

endmodule
